// File: rtl/universal_range_counter.sv
// Up/down range counter with runtime bounds, programmable step and wrap/saturate mode.
// Adds a registered terminal-count pulse, a sticky overflow flag and a config-error flag.
module universal_range_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_syn_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_lim_lo,
    input  logic [WIDTH-1:0] i_lim_hi,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_q,
    output logic             o_min,
    output logic             o_max,
    output logic             o_tc,
    output logic             o_ovf,
    output logic             o_cfg_err
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_qNext;
    logic             r_tc;
    logic             w_tcNext;
    logic             r_ovf;
    logic             w_ovfNext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_room;
    logic             w_cfgErr;
    logic             w_cross;

    assign w_cfgErr = (i_lim_lo > i_lim_hi);
    assign w_sum    = {1'b0, r_q} + {1'b0, i_step};
    assign w_room   = {1'b0, r_q} - {1'b0, i_lim_lo};

    // A q already below lim_lo has no room at all, so any downward step crosses.
    always_comb begin
        if (i_up) begin
            w_cross = (w_sum > {1'b0, i_lim_hi});
        end else begin
            w_cross = (r_q < i_lim_lo) || ({1'b0, i_step} > w_room);
        end
    end

    always_comb begin
        w_qNext   = r_q;
        w_tcNext  = 1'b0;
        w_ovfNext = r_ovf;
        if (w_cfgErr) begin
            w_qNext = r_q;
        end else if (i_syn_clr) begin
            w_qNext   = i_lim_lo;
            w_ovfNext = 1'b0;
        end else if (i_load) begin
            if (i_data < i_lim_lo) begin
                w_qNext = i_lim_lo;
            end else if (i_data > i_lim_hi) begin
                w_qNext = i_lim_hi;
            end else begin
                w_qNext = i_data;
            end
        end else if (i_en && (i_step != '0)) begin
            if (w_cross) begin
                w_tcNext  = 1'b1;
                w_ovfNext = 1'b1;
                if (i_up) begin
                    w_qNext = i_sat ? i_lim_hi : i_lim_lo;
                end else begin
                    w_qNext = i_sat ? i_lim_lo : i_lim_hi;
                end
            end else if (i_up) begin
                w_qNext = w_sum[WIDTH-1:0];
            end else begin
                w_qNext = r_q - i_step;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_qNext;
            r_tc  <= w_tcNext;
            r_ovf <= w_ovfNext;
        end
    end

    assign o_q       = r_q;
    assign o_tc      = r_tc;
    assign o_ovf     = r_ovf;
    assign o_min     = (r_q == i_lim_lo);
    assign o_max     = (r_q == i_lim_hi);
    assign o_cfg_err = w_cfgErr;

endmodule

// File: tb/tb_universal_range_counter.sv
// Directed-vector bench for universal_range_counter: stimulus pushes hand-computed
// expectations into a queue, a separate monitor pops and compares after each update.
module tb_universal_range_counter;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             ovf;
        logic             mn;
        logic             mx;
        logic             cfg;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             syn_clr = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             en = 1'b0;
    logic             up = 1'b0;
    logic [WIDTH-1:0] step = '0;
    logic [WIDTH-1:0] lim_lo = '0;
    logic [WIDTH-1:0] lim_hi = '0;
    logic             sat = 1'b0;
    logic [WIDTH-1:0] q;
    logic             minFlag;
    logic             maxFlag;
    logic             tc;
    logic             ovf;
    logic             cfgErr;

    logic [WIDTH-1:0] cLo;
    logic [WIDTH-1:0] cHi;
    logic [WIDTH-1:0] cStep;
    logic             cUp;
    logic             cSat;

    exp_t  expQ[$];
    string nameQ[$];
    int    errors = 0;
    int    checks = 0;

    universal_range_counter #(.WIDTH(WIDTH)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_syn_clr (syn_clr),
        .i_load    (load),
        .i_data    (data),
        .i_en      (en),
        .i_up      (up),
        .i_step    (step),
        .i_lim_lo  (lim_lo),
        .i_lim_hi  (lim_hi),
        .i_sat     (sat),
        .o_q       (q),
        .o_min     (minFlag),
        .o_max     (maxFlag),
        .o_tc      (tc),
        .o_ovf     (ovf),
        .o_cfg_err (cfgErr)
    );

    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input string field,
                               input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, expv);
        end
    endtask

    task automatic setConfig(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                             input logic [WIDTH-1:0] st, input logic u, input logic s);
        cLo   = lo;
        cHi   = hi;
        cStep = st;
        cUp   = u;
        cSat  = s;
    endtask

    task automatic pushExpect(input string name, input logic [WIDTH-1:0] eq,
                              input logic etc, input logic eovf);
        exp_t e;
        e.q   = eq;
        e.tc  = etc;
        e.ovf = eovf;
        e.mn  = (eq == cLo);
        e.mx  = (eq == cHi);
        e.cfg = (cLo > cHi);
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic driveInputs(input logic clr, input logic ld,
                               input logic [WIDTH-1:0] d, input logic e);
        syn_clr = clr;
        load    = ld;
        data    = d;
        en      = e;
        up      = cUp;
        step    = cStep;
        lim_lo  = cLo;
        lim_hi  = cHi;
        sat     = cSat;
    endtask

    // One clocked vector: inputs change on the falling edge, result is due after the next rising edge.
    task automatic applyStimulus(input string name, input logic clr, input logic ld,
                                 input logic [WIDTH-1:0] d, input logic e,
                                 input logic [WIDTH-1:0] eq, input logic etc, input logic eovf);
        @(negedge clk);
        reset_n = 1'b1;
        driveInputs(clr, ld, d, e);
        pushExpect(name, eq, etc, eovf);
    endtask

    // Reset dropped between edges with the counter enabled; outputs must clear at once.
    task automatic asyncReset(input string name);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, '0, 1'b1);
        #2;
        reset_n = 1'b0;
        pushExpect(name, '0, 1'b0, 1'b0);
    endtask

    // Monitor: wakes on every register update (clock or async reset) and checks any pending expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, "q",       q,                   e.q);
                checkOutput(n, "tc",      {7'd0, tc},          {7'd0, e.tc});
                checkOutput(n, "ovf",     {7'd0, ovf},         {7'd0, e.ovf});
                checkOutput(n, "min",     {7'd0, minFlag},     {7'd0, e.mn});
                checkOutput(n, "max",     {7'd0, maxFlag},     {7'd0, e.mx});
                checkOutput(n, "cfg_err", {7'd0, cfgErr},      {7'd0, e.cfg});
            end
        end
    end

    // Stimulus thread: directed vectors with hand-computed results.
    initial begin
        setConfig(8'd0, 8'd255, 8'd1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);

        asyncReset("reset");
        applyStimulus("t1_cnt1",   0, 0, 8'd0, 1, 8'd1, 0, 0);
        applyStimulus("t1_cnt2",   0, 0, 8'd0, 1, 8'd2, 0, 0);
        applyStimulus("t1_cnt3",   0, 0, 8'd0, 1, 8'd3, 0, 0);
        asyncReset("t1_midrst");
        applyStimulus("t1_resume", 0, 0, 8'd0, 1, 8'd1, 0, 0);

        setConfig(8'd3, 8'd10, 8'd2, 1'b1, 1'b0);
        applyStimulus("t2_load7",  0, 1, 8'd7, 0, 8'd7, 0, 0);
        applyStimulus("t2_up9",    0, 0, 8'd0, 1, 8'd9, 0, 0);
        applyStimulus("t2_wrap",   0, 0, 8'd0, 1, 8'd3, 1, 1);
        applyStimulus("t2_up5",    0, 0, 8'd0, 1, 8'd5, 0, 1);

        setConfig(8'd3, 8'd10, 8'd4, 1'b0, 1'b1);
        applyStimulus("t3_satlo",  0, 0, 8'd0, 1, 8'd3, 1, 1);
        applyStimulus("t3_again",  0, 0, 8'd0, 1, 8'd3, 1, 1);
        applyStimulus("t3_idle",   0, 0, 8'd0, 0, 8'd3, 0, 1);

        setConfig(8'd0, 8'd100, 8'd1, 1'b1, 1'b0);
        applyStimulus("t5_clamphi", 0, 1, 8'd200, 0, 8'd100, 0, 1);
        applyStimulus("t5_clrload", 1, 1, 8'd50,  1, 8'd0,   0, 0);
        setConfig(8'd20, 8'd100, 8'd1, 1'b1, 1'b0);
        applyStimulus("t5_clamplo", 0, 1, 8'd5,   0, 8'd20,  0, 0);
        applyStimulus("t5_loadin",  0, 1, 8'd50,  1, 8'd50,  0, 0);

        setConfig(8'd0, 8'd255, 8'd1, 1'b1, 1'b0);
        applyStimulus("t4_loadFE", 0, 1, 8'hFE, 0, 8'hFE, 0, 0);
        applyStimulus("t4_toFF",   0, 0, 8'd0,  1, 8'hFF, 0, 0);
        applyStimulus("t4_wrap00", 0, 0, 8'd0,  1, 8'h00, 1, 1);
        applyStimulus("t4_to01",   0, 0, 8'd0,  1, 8'h01, 0, 1);

        setConfig(8'd0, 8'd255, 8'd1, 1'b0, 1'b0);
        applyStimulus("dn_land0",  0, 0, 8'd0, 1, 8'h00, 0, 1);
        applyStimulus("dn_wrapFF", 0, 0, 8'd0, 1, 8'hFF, 1, 1);

        setConfig(8'd0, 8'd255, 8'd10, 1'b1, 1'b1);
        applyStimulus("up_sat9bit", 0, 0, 8'd0, 1, 8'hFF, 1, 1);
        setConfig(8'd0, 8'd255, 8'd0, 1'b1, 1'b1);
        applyStimulus("step0_hold", 0, 0, 8'd0, 1, 8'hFF, 0, 1);

        setConfig(8'd40, 8'd40, 8'd1, 1'b1, 1'b0);
        applyStimulus("eq_load",   0, 1, 8'd40, 0, 8'd40, 0, 1);
        applyStimulus("eq_cross",  0, 0, 8'd0,  1, 8'd40, 1, 1);
        applyStimulus("eq_clr",    1, 0, 8'd0,  0, 8'd40, 0, 0);

        setConfig(8'd20, 8'd10, 8'd1, 1'b1, 1'b0);
        applyStimulus("t6_cfgall", 1, 1, 8'd15, 1, 8'd40, 0, 0);
        applyStimulus("t6_cfgen",  0, 0, 8'd0,  1, 8'd40, 0, 0);
        setConfig(8'd0, 8'd10, 8'd1, 1'b1, 1'b0);
        applyStimulus("t6_oorup",  0, 0, 8'd0,  1, 8'd0,  1, 1);
        applyStimulus("t6_resume", 0, 0, 8'd0,  1, 8'd1,  0, 1);

        setConfig(8'd5, 8'd10, 8'd1, 1'b0, 1'b1);
        applyStimulus("oor_dnsat", 0, 0, 8'd0, 1, 8'd5, 1, 1);
        applyStimulus("lo_dnsat",  0, 0, 8'd0, 1, 8'd5, 1, 1);

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
